// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants: NOP encoding, reset PC,
// and the entry layouts carried by the two fetch queues.
package fetch_stage_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic        epoch;
  } fetch_tag_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_word_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: valid/ready request channel plus an in-order,
// non-backpressured response channel.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/fetch_stage_queue.sv
// Small synchronous FIFO with a combinational head; flush empties it in one cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_stage_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i;

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  always_comb begin
    rd_d  = rd_q + PTR_W'(do_pop);
    wr_d  = wr_q + PTR_W'(do_push);
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
    if (rst_n && do_push) assert (!full_o || do_pop);
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: owns the fetch PC, issues credit-limited imem requests and
// buffers returned words; a 1-bit epoch discards responses from before a redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          FQ_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 redirect_valid_i,
  input  logic [31:0]          redirect_pc_i,
  fetch_stage_if.master        imem,
  output logic [31:0]          inst_f_o,
  output logic [31:0]          pc_f_o
);
  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             epoch_q, epoch_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             run_q;

  fetch_tag_t       tag_in, tag_head;
  fetch_word_t      word_in, word_head;
  logic             tag_full, tag_empty, word_full, word_empty;
  logic [CNT_W-1:0] tag_count, word_count;
  logic [CNT_W:0]   credit_used;
  logic             accept, rsp_take, rsp_keep;

  // Credits cover both words in flight and words already queued, so the word queue cannot overflow.
  assign credit_used         = {1'b0, outstanding_q} + {1'b0, word_count};
  assign imem.imem_req_valid = run_q && !redirect_valid_i
                               && (credit_used < (CNT_W+1)'(FQ_DEPTH));
  assign imem.imem_req_addr  = fetch_pc_q;

  assign accept   = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_take = imem.imem_rsp_valid && !tag_empty;
  assign rsp_keep = rsp_take && (tag_head.epoch == epoch_q) && !redirect_valid_i;

  assign tag_in  = '{pc: fetch_pc_q, epoch: epoch_q};
  assign word_in = '{pc: tag_head.pc, inst: imem.imem_rsp_data};

  fetch_stage_queue #(.WIDTH($bits(fetch_tag_t)), .DEPTH(FQ_DEPTH)) u_tag_q (
    .clk(clk), .rst_n(rst_n),
    .push_i(accept), .pop_i(rsp_take), .flush_i(1'b0),
    .data_i(tag_in), .data_o(tag_head),
    .full_o(tag_full), .empty_o(tag_empty), .count_o(tag_count)
  );

  fetch_stage_queue #(.WIDTH($bits(fetch_word_t)), .DEPTH(FQ_DEPTH)) u_word_q (
    .clk(clk), .rst_n(rst_n),
    .push_i(rsp_keep), .pop_i(!stall_i), .flush_i(redirect_valid_i),
    .data_i(word_in), .data_o(word_head),
    .full_o(word_full), .empty_o(word_empty), .count_o(word_count)
  );

  assign inst_f_o = word_empty ? NOP   : word_head.inst;
  assign pc_f_o   = word_empty ? '0    : word_head.pc;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    epoch_d       = epoch_q;
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(rsp_take);
    if (redirect_valid_i) begin
      fetch_pc_d = word_align(redirect_pc_i);
      epoch_d    = ~epoch_q;
    end else if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      epoch_q       <= 1'b0;
      outstanding_q <= '0;
      run_q         <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      epoch_q       <= epoch_d;
      outstanding_q <= outstanding_d;
      run_q         <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (tag_count == outstanding_q);
      assert (!(accept && tag_full));
      assert (!(rsp_keep && word_full));
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage against an in-order memory model
// and a PC-stream reference (expected request and decode PCs advance by 4, reset on redirect).
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0100_0000;

  typedef struct {
    logic [31:0] pc;
    int          due;
    int          gen;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] inst_f, pc_f;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall),
    .redirect_valid_i(redirect), .redirect_pc_i(redirect_pc),
    .imem(bus), .inst_f_o(inst_f), .pc_f_o(pc_f)
  );

  always #5 clk = ~clk;

  int          n_vec = 0, n_fail = 0, n_dec = 0, cyc = 0, gen = 0, last_due = 0;
  int          lat_fixed = 1;
  bit          lat_rand = 0, rand_mode = 0, inject_stale = 0;
  pend_t       pend[$];
  logic [31:0] exp_req_pc = RST_PC, exp_dec_pc = RST_PC;
  bit          prev_redirect = 0, prev_hold_req = 0, prev_hold_head = 0;
  logic [31:0] prev_addr = '0, prev_inst = '0, prev_pc = '0;
  bit          want_first_req = 0, want_first_dec = 0;
  logic [31:0] first_req = '0, first_dec = '0;

  function automatic logic [31:0] memword(input logic [31:0] pc);
    return {pc[31:2], 2'b10} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_prev();
    prev_redirect = 0; prev_hold_req = 0; prev_hold_head = 0;
  endtask

  // One pipeline cycle: drive inputs, sample mid-cycle, update the model, advance to next negedge.
  task automatic step();
    logic v, rdy;
    logic [31:0] a, ins, pcv;
    bit safe;
    int lat, due;
    if (rand_mode) begin
      stall = ($urandom_range(99) < 30);
      bus.imem_req_ready = ($urandom_range(99) < 70);
      safe = 1;
      foreach (pend[i]) if (pend[i].gen != gen) safe = 0;
      redirect = safe && ($urandom_range(99) < 4);
      redirect_pc = $urandom();
    end
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (inject_stale) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'h0BAD_0002;
      inject_stale = 0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memword(pend[0].pc);
      void'(pend.pop_front());
    end
    #1;
    v = bus.imem_req_valid; rdy = bus.imem_req_ready; a = bus.imem_req_addr;
    ins = inst_f; pcv = pc_f;
    if (prev_redirect) begin
      chk("flush_inst", ins, NOP);
      chk("flush_pc", pcv, 32'h0);
    end
    if (prev_hold_req && !redirect) begin
      chk("req_hold_valid", {31'b0, v}, 32'h1);
      chk("req_hold_addr", a, prev_addr);
    end
    if (prev_hold_head) begin
      chk("stall_hold_inst", ins, prev_inst);
      chk("stall_hold_pc", pcv, prev_pc);
    end
    if (redirect) chk("redir_no_req", {31'b0, v}, 32'h0);
    if (v && rdy) begin
      chk("req_addr", a, exp_req_pc);
      if (want_first_req) begin first_req = a; want_first_req = 0; end
      lat = lat_rand ? int'($urandom_range(4, 1)) : lat_fixed;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{pc: a, due: due, gen: gen});
      exp_req_pc = exp_req_pc + 32'd4;
      chk("credit_bound", {31'b0, (pend.size() <= DEPTH)}, 32'h1);
    end
    if (!stall && !redirect) begin
      if (ins == NOP) begin
        chk("bubble_pc", pcv, 32'h0);
      end else begin
        chk("dec_pc", pcv, exp_dec_pc);
        chk("dec_inst", ins, memword(exp_dec_pc));
        if (want_first_dec) begin first_dec = pcv; want_first_dec = 0; end
        exp_dec_pc = exp_dec_pc + 32'd4;
        n_dec++;
      end
    end
    if (redirect) begin
      exp_req_pc = {redirect_pc[31:2], 2'b00};
      exp_dec_pc = exp_req_pc;
      gen++;
      want_first_req = 1; want_first_dec = 1;
    end
    prev_redirect  = redirect;
    prev_hold_req  = v && !rdy && !redirect;
    prev_addr      = a;
    prev_hold_head = stall && !redirect && (ins != NOP);
    prev_inst      = ins;
    prev_pc        = pcv;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int start = n_dec;
    int k = 0;
    while (n_dec - start < n && k < budget) begin step(); k++; end
    chk(tag, {31'b0, (n_dec - start >= n)}, 32'h1);
    $display("phase %s: %0d instructions decoded in %0d cycles", tag, n_dec - start, k);
  endtask

  task automatic do_redirect(input logic [31:0] target, input bit with_stall);
    redirect = 1'b1; redirect_pc = target; stall = with_stall;
    step();
    redirect = 1'b0; stall = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    bus.imem_req_ready = 1'b0; stall = 1'b0;
    while (pend.size() > 0 && k < 20) begin step(); k++; end
    chk(tag, pend.size(), 32'h0);
    bus.imem_req_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, bus.imem_req_valid}, 32'h0);
    chk({tag, "_inst"}, inst_f, NOP);
    chk({tag, "_pc"}, pc_f, 32'h0);
  endtask

  initial begin
    int k;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    check_reset_outputs("por_hold");
    rst_n = 1'b1;

    // Streaming fetch after reset, 1-cycle memory
    lat_fixed = 1;
    run_until("stream", 8, 40);

    // Decode stall for 3 cycles
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    run_until("after_stall", 4, 30);

    // Redirect with two requests outstanding
    lat_fixed = 3;
    k = 0;
    while (pend.size() < 2 && k < 20) begin step(); k++; end
    chk("two_inflight", {31'b0, (pend.size() >= 2)}, 32'h1);
    do_redirect(32'h0100_0203, 1'b0);
    run_until("after_redirect", 4, 40);
    chk("redir_first_req", first_req, 32'h0100_0200);
    chk("redir_first_dec", first_dec, 32'h0100_0200);

    // Memory not ready for 5 cycles
    bus.imem_req_ready = 1'b0;
    repeat (5) step();
    #1;
    chk("drained_inst", inst_f, NOP);
    chk("drained_pc", pc_f, 32'h0);
    bus.imem_req_ready = 1'b1;
    run_until("after_not_ready", 4, 40);

    // Asynchronous reset mid-burst with a response pending
    lat_fixed = 2;
    k = 0;
    while (pend.size() == 0 && k < 20) begin step(); k++; end
    chk("pending_before_reset", {31'b0, (pend.size() > 0)}, 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    pend.delete(); last_due = 0;
    exp_req_pc = RST_PC; exp_dec_pc = RST_PC;
    clear_prev(); stall = 1'b0; redirect = 1'b0;
    want_first_req = 1; want_first_dec = 1;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    inject_stale = 1;
    run_until("after_reset", 4, 40);
    chk("rst_first_req", first_req, RST_PC);
    chk("rst_first_dec", first_dec, RST_PC);

    // Address wrap at the top of the address space
    lat_fixed = 1;
    do_redirect(32'hFFFF_FFF4, 1'b0);
    run_until("wrap", 6, 40);

    // Redirect, stall and response all in one cycle
    k = 0;
    while (!(pend.size() > 0 && pend[0].due <= cyc) && k < 20) begin step(); k++; end
    chk("rsp_due_for_redirect", {31'b0, (pend.size() > 0)}, 32'h1);
    do_redirect(32'h0100_0400, 1'b1);
    run_until("redir_stall_rsp", 4, 40);
    chk("rsr_first_dec", first_dec, 32'h0100_0400);

    // Two redirects two cycles apart, then back to back
    drain("drain_a");
    do_redirect(32'h0100_0800, 1'b0);
    step();
    do_redirect(32'h0100_0900, 1'b0);
    step();
    do_redirect(32'h0100_0A00, 1'b0);
    do_redirect(32'h0100_0B02, 1'b0);
    run_until("double_redirect", 4, 40);
    chk("dbl_first_dec", first_dec, 32'h0100_0B00);

    // Randomized traffic: stalls, backpressure, variable latency, redirects
    drain("drain_b");
    lat_rand = 1; rand_mode = 1;
    k = n_dec;
    repeat (1500) step();
    rand_mode = 0; stall = 1'b0; redirect = 1'b0;
    chk("random_progress", {31'b0, (n_dec - k > 50)}, 32'h1);
    $display("phase random: %0d instructions decoded", n_dec - k);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
